// File: rtl/load_scoreboard_if.sv
// Hazard-control bundle between the 5-stage pipeline and the load scoreboard.
// LOAD_SCOREBOARD_PERF_EN adds the stall performance counters to the bundle.
interface load_scoreboard_if #(
    parameter int unsigned NREGS = 32
);
    localparam int unsigned RW = $clog2(NREGS);

    logic [RW-1:0]    RS1D;
    logic [RW-1:0]    RS2D;
    logic [RW-1:0]    RdD;
    logic             ValidD;
    logic             LoadD;
    logic [RW-1:0]    RdM;
    logic             LoadM;
    logic             MemReqM;
    logic             MemReadyM;
    logic             BranchTakenE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             StallE;
    logic             FlushE;
    logic             StallM;
    logic             FlushW;
    logic [NREGS-1:0] PendingMask;
`ifdef LOAD_SCOREBOARD_PERF_EN
    logic [31:0]      LuStallCnt;
    logic [31:0]      MemStallCnt;

    modport master (
        output RS1D, RS2D, RdD, ValidD, LoadD, RdM, LoadM, MemReqM, MemReadyM, BranchTakenE,
        input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, PendingMask,
        input  LuStallCnt, MemStallCnt
    );
    modport slave (
        input  RS1D, RS2D, RdD, ValidD, LoadD, RdM, LoadM, MemReqM, MemReadyM, BranchTakenE,
        output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, PendingMask,
        output LuStallCnt, MemStallCnt
    );
`else
    modport master (
        output RS1D, RS2D, RdD, ValidD, LoadD, RdM, LoadM, MemReqM, MemReadyM, BranchTakenE,
        input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, PendingMask
    );
    modport slave (
        input  RS1D, RS2D, RdD, ValidD, LoadD, RdM, LoadM, MemReqM, MemReadyM, BranchTakenE,
        output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW, PendingMask
    );
`endif
endinterface

// File: rtl/load_scoreboard.sv
// Load scoreboard: tracks in-flight load destinations and produces stall/flush controls.
// Optional stall performance counters are enabled with LOAD_SCOREBOARD_PERF_EN.
module load_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 2
) (
    input logic              clk,
    input logic              rst,
    load_scoreboard_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [NREGS-1:0] pending_mask;

    logic mem_stall;
    logic lu_stall;
    logic src1_busy;
    logic src2_busy;
    logic issue;
    logic retire;
    logic same_reg;
    logic inc_ovf;
    logic dec_unf;

    // Hazard conditions; sources are checked whether or not the instruction reads them.
    always_comb begin
        mem_stall = bus.MemReqM && !bus.MemReadyM;
        src1_busy = (bus.RS1D != '0) && (cnt_q[bus.RS1D] != '0);
        src2_busy = (bus.RS2D != '0) && (cnt_q[bus.RS2D] != '0);
        lu_stall  = bus.ValidD && (src1_busy || src2_busy);
        issue     = bus.ValidD && bus.LoadD && (bus.RdD != '0) &&
                    !mem_stall && !bus.BranchTakenE && !lu_stall;
        retire    = bus.LoadM && (bus.RdM != '0) && bus.MemReqM && bus.MemReadyM;
        same_reg  = bus.RdD == bus.RdM;
        inc_ovf   = issue && !(retire && same_reg) && (cnt_q[bus.RdD] == CNT_MAX);
        dec_unf   = retire && !(issue && same_reg) && (cnt_q[bus.RdM] == '0);
    end

    // Prioritised pipeline controls; a memory wait freezes everything up to M.
    always_comb begin
        bus.StallF = 1'b0;
        bus.StallD = 1'b0;
        bus.FlushD = 1'b0;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        bus.StallM = 1'b0;
        bus.FlushW = 1'b0;
        if (rst) begin
            if (mem_stall) begin
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
                bus.StallE = 1'b1;
                bus.StallM = 1'b1;
                bus.FlushW = 1'b1;
            end else if (bus.BranchTakenE) begin
                bus.FlushD = 1'b1;
                bus.FlushE = 1'b1;
            end else if (lu_stall) begin
                bus.StallF = 1'b1;
                bus.StallD = 1'b1;
                bus.FlushE = 1'b1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            pending_mask[r] = cnt_q[r] != '0;
        end
        bus.PendingMask = pending_mask;
    end

    // Issue and retire of the same register cancel; out-of-range moves saturate.
    always_comb begin
        cnt_d    = cnt_q;
        cnt_d[0] = '0;
        if (!(issue && retire && same_reg)) begin
            if (issue && (cnt_q[bus.RdD] != CNT_MAX)) begin
                cnt_d[bus.RdD] = cnt_q[bus.RdD] + CNT_W'(1);
            end
            if (retire && (cnt_q[bus.RdM] != '0)) begin
                cnt_d[bus.RdM] = cnt_q[bus.RdM] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef LOAD_SCOREBOARD_PERF_EN
    logic [31:0] lu_cnt_q;
    logic [31:0] lu_cnt_d;
    logic [31:0] mem_cnt_q;
    logic [31:0] mem_cnt_d;

    // Free-running stall counters, wrapping at 2^32.
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (mem_stall) begin
            mem_cnt_d = mem_cnt_q + 32'(1);
        end else if (!bus.BranchTakenE && lu_stall) begin
            lu_cnt_d = lu_cnt_q + 32'(1);
        end
        bus.LuStallCnt  = lu_cnt_q;
        bus.MemStallCnt = mem_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end
`endif

    // Counter overflow/underflow means the pipeline broke the load protocol.
    a_no_inc_ovf: assert property (@(posedge clk) disable iff (!rst) !inc_ovf);
    a_no_dec_unf: assert property (@(posedge clk) disable iff (!rst) !dec_unf);

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Producer-side hazard block; the counterpart to the EX-stage forwarding selector.
- Tracks destination registers of loads in flight between the D->E issue and M completion.
- Generates load-use stalls, branch flushes and variable-latency memory stalls for the 5-stage pipeline.
- Once a load's data reaches W, the forwarding path covers it, so pending state clears when the load leaves M.

Parameters:
- NREGS, 32, architectural register count; register x0 is never tracked.
- CNT_W, 2, width of each per-register in-flight load counter (at most 2 loads live in E+M).

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-low reset (rst==0 resets).
- RS1D  input  5  source register 1 of the instruction in D.
- RS2D  input  5  source register 2 of the instruction in D.
- RdD  input  5  destination register of the instruction in D.
- ValidD  input  1  D holds a real instruction (not a bubble).
- LoadD  input  1  instruction in D is a load with RegwriteD=1.
- RdM  input  5  destination register of the instruction in M.
- LoadM  input  1  instruction in M is a load.
- MemReqM  input  1  M is issuing a data-memory access (load or store).
- MemReadyM  input  1  data memory completes the M access this cycle.
- BranchTakenE  input  1  redirect resolved in E.
- StallF  output  1  hold PC.
- StallD  output  1  hold the IF/ID register.
- FlushD  output  1  clear the IF/ID register.
- StallE  output  1  hold the ID/EX register.
- FlushE  output  1  clear the ID/EX register (insert bubble).
- StallM  output  1  hold the EX/MEM register.
- FlushW  output  1  clear the MEM/WB register.
- PendingMask  output  NREGS  bit r = counter r nonzero (debug/verification visibility).

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-low. While rst==0, all counters clear to 0 and every output is 0.
- State: cnt[r] (CNT_W bits) for r=1..NREGS-1; cnt[0] is tied to 0.
- Derived conditions:
  - mem_stall = MemReqM & ~MemReadyM.
  - lu_stall = ValidD & ((RS1D!=0 & cnt[RS1D]!=0) | (RS2D!=0 & cnt[RS2D]!=0)). The check is conservative: sources are tested even when the instruction does not use them.
- Output priority (combinational from state and inputs, zero latency):
  1. mem_stall: StallF=StallD=StallE=StallM=1, FlushW=1, all others 0.
  2. else BranchTakenE: FlushD=1, FlushE=1, all others 0. This overrides lu_stall because the D instruction is discarded.
  3. else lu_stall: StallF=1, StallD=1, FlushE=1, all others 0.
  4. else all outputs 0.
- Counter events (registered, take effect on the next clk edge):
  - issue = ValidD & LoadD & RdD!=0 & ~mem_stall & ~BranchTakenE & ~lu_stall.
  - retire = LoadM & RdM!=0 & MemReqM & MemReadyM.
  - issue only: cnt[RdD] increments.
  - retire only: cnt[RdM] decrements.
  - Both, with RdD==RdM: counter unchanged.
  - Both, with different registers: each counter updates independently.
  - During mem_stall: no issue, and no retire because MemReadyM=0. Counters hold.
- Boundaries:
  - Increment at max value (2^CNT_W-1): saturate and hold; this is a protocol error.
  - Decrement at 0: hold at 0; this is a protocol error.
  - Both error cases are flagged by simulation assertions only.
- Load-use latency: a dependent instruction directly behind a load stalls in D for exactly 2 cycles with single-cycle memory (load in E, then load in M). It proceeds once the load reaches W.
- Reset mid-operation: all counters clear immediately. Any pending loads are forgotten, because the pipeline registers reset as well.
- PendingMask[0] is always 0.

Optional Feature:
- Macro: LOAD_SCOREBOARD_PERF_EN.
- Defined: adds outputs LuStallCnt[31:0] and MemStallCnt[31:0].
  - Each is a free-running counter, incremented on every cycle where priority case 3 (respectively case 1) is active.
  - Both wrap at 2^32 and reset to 0 on rst==0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 with arbitrary inputs -> all outputs 0, PendingMask=0. Release rst, issue a load to x5 -> PendingMask[5]=1 on the next cycle.
- Load-use: `lw x5` followed by `add x6,x5,x7`, MemReadyM tied 1 -> StallF/StallD/FlushE high for 2 cycles, then 0; PendingMask[5] clears the cycle after the load leaves M.
- x0 load: `lw x0` followed by a consumer of x0 -> no stall, PendingMask stays 0.
- Memory wait: load in M with MemReadyM=0 for 3 cycles -> StallF..StallM=1 and FlushW=1 for 3 cycles, cnt held; retire occurs on the ready cycle.
- Branch vs load-use: BranchTakenE=1 while lu_stall is true -> FlushD=1, FlushE=1, StallD=0, and the load in D is not issued (cnt unchanged).
- Simultaneous: back-to-back loads to x9 -> cnt[9] reaches 2. Issue of a third x9 load in the same cycle the first retires -> cnt[9] stays 2.
